// File: rtl/jpeg_dec_pkg.sv
// Shared definitions for the JPEG coefficient block decoder.
//   ZZ         : zigzag index -> raster index table
//   EOB_RS     : AC run/size code for end-of-block
//   ZRL_RS     : AC run/size code for a run of sixteen zeros
//   dec_state_t: decoder FSM states
//   extend()   : JPEG amplitude-bit sign extension into 18-bit signed
//   sat_coeff(): optional saturation of an 18-bit value to a w-bit signed range
package jpeg_dec_pkg;

    localparam logic [5:0] ZZ [0:63] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    localparam logic [7:0] EOB_RS = 8'h00;
    localparam logic [7:0] ZRL_RS = 8'hF0;

    typedef enum logic [1:0] {
        ST_WAIT_DC,
        ST_AC,
        ST_OUT
    } dec_state_t;

    // Low s bits of v are the amplitude; a clear top bit marks a negative value.
    function automatic logic signed [17:0] extend(input logic [17:0] v, input logic [3:0] s);
        logic [17:0] mask;
        logic [17:0] val;
        if (s == 4'd0) return '0;
        mask = (18'd1 << s) - 18'd1;
        val  = v & mask;
        if (val[s - 4'd1]) return $signed(val);
        return $signed(val - mask);
    endfunction

    // With sat_en clear the value is returned untouched; the caller truncates.
    function automatic logic signed [17:0] sat_coeff(input logic signed [17:0] x,
                                                     input int unsigned w,
                                                     input logic sat_en);
        logic signed [17:0] hi;
        logic signed [17:0] lo;
        hi = (18'sd1 <<< (w - 1)) - 18'sd1;
        lo = -hi - 18'sd1;
        if (!sat_en) return x;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/jpeg_dezigzag_rom.sv
// Inverse zigzag lookup: maps a zigzag scan position to its raster position.
//   zz_idx     in  6  zigzag scan index (0..63)
//   raster_idx out 6  raster index (row*8 + col)
module jpeg_dezigzag_rom
    import jpeg_dec_pkg::*;
(
    input  logic [5:0] zz_idx,
    output logic [5:0] raster_idx
);

    assign raster_idx = ZZ[zz_idx];

endmodule

// File: rtl/jpeg_coeff_block_decoder.sv
// Rebuilds 8x8 blocks of quantized coefficients from a Huffman-decoded symbol
// stream: DC prediction per component, run-length expansion, inverse zigzag.
//   clock, reset_n                  : rising-edge clock, synchronous active-low reset
//   sym_valid/sym_ready             : one symbol per accepted cycle
//   sym_is_dc, sym_rs, sym_amp      : symbol kind, {run,size} / DC size, amplitude bits
//   is_luminance                    : DC predictor select, sampled with the DC symbol
//   restart                         : clears both DC predictors
//   blk_valid/blk_ready             : block handshake toward dequantize/IDCT
//   blk_coeffs                      : raster coeff r at [r*COEFF_W +: COEFF_W]
//   blk_is_luminance, blk_err       : block component and protocol-error flag
//   err                             : one-cycle pulse per erroneous symbol
module jpeg_coeff_block_decoder
    import jpeg_dec_pkg::*;
#(
    parameter int COEFF_W = 10,
    parameter int AMP_W   = 16,
    parameter bit SAT_EN  = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   sym_valid,
    output logic                   sym_ready,
    input  logic                   sym_is_dc,
    input  logic [7:0]             sym_rs,
    input  logic [AMP_W-1:0]       sym_amp,
    input  logic                   is_luminance,
    input  logic                   restart,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic [64*COEFF_W-1:0]  blk_coeffs,
    output logic                   blk_is_luminance,
    output logic                   blk_err,
    output logic                   err
);

    dec_state_t                state;
    logic [6:0]                k;
    logic signed [COEFF_W-1:0] pred_lum;
    logic signed [COEFF_W-1:0] pred_chr;
    logic [64*COEFF_W-1:0]     coeffs;

    logic                      accept;
    logic [3:0]                run;
    logic [3:0]                size;
    logic [6:0]                k_run;
    logic [6:0]                k_zrl;
    logic [5:0]                raster_idx;
    logic                      dc_size_bad;
    logic                      ac_bad;
    logic [17:0]               amp_ext;
    logic signed [17:0]        pred_sel;
    logic signed [17:0]        dc_diff;
    logic [COEFF_W-1:0]        dc_val;
    logic [COEFF_W-1:0]        ac_val;

    assign sym_ready  = reset_n && (state != ST_OUT);
    assign accept     = sym_valid && sym_ready;
    assign blk_coeffs = coeffs;
    assign amp_ext    = 18'(sym_amp);

    always_comb begin
        run         = sym_rs[7:4];
        size        = sym_rs[3:0];
        k_run       = k + {3'b000, run};
        k_zrl       = k + 7'd16;
        dc_size_bad = (size > 4'd11);
        ac_bad      = (size == 4'd0) || (size > 4'd10);
        // restart takes effect ahead of a DC decoded in the same cycle
        if (restart)           pred_sel = '0;
        else if (is_luminance) pred_sel = 18'(pred_lum);
        else                   pred_sel = 18'(pred_chr);
        dc_diff = dc_size_bad ? '0 : extend(amp_ext, size);
        dc_val  = COEFF_W'(sat_coeff(pred_sel + dc_diff, COEFF_W, SAT_EN));
        ac_val  = ac_bad ? '0 : COEFF_W'(sat_coeff(extend(amp_ext, size), COEFF_W, SAT_EN));
    end

    jpeg_dezigzag_rom u_dezigzag (
        .zz_idx     (k_run[5:0]),
        .raster_idx (raster_idx)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= ST_WAIT_DC;
            k                <= '0;
            pred_lum         <= '0;
            pred_chr         <= '0;
            coeffs           <= '0;
            blk_valid        <= 1'b0;
            blk_is_luminance <= 1'b0;
            blk_err          <= 1'b0;
            err              <= 1'b0;
        end else begin
            err <= 1'b0;
            if (restart) begin
                pred_lum <= '0;
                pred_chr <= '0;
            end
            case (state)
                ST_WAIT_DC: begin
                    if (accept) begin
                        if (sym_is_dc) begin
                            coeffs <= {{(63*COEFF_W){1'b0}}, dc_val};
                            if (is_luminance) pred_lum <= dc_val;
                            else              pred_chr <= dc_val;
                            blk_is_luminance <= is_luminance;
                            blk_err          <= dc_size_bad;
                            err              <= dc_size_bad;
                            k                <= 7'd1;
                            state            <= ST_AC;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_AC: begin
                    if (accept) begin
                        if (sym_is_dc) begin
                            err       <= 1'b1;
                            blk_err   <= 1'b1;
                            blk_valid <= 1'b1;
                            state     <= ST_OUT;
                        end else if (sym_rs == EOB_RS) begin
                            blk_valid <= 1'b1;
                            state     <= ST_OUT;
                        end else if (sym_rs == ZRL_RS) begin
                            k <= k_zrl;
                            if (k_zrl > 7'd64) begin
                                err     <= 1'b1;
                                blk_err <= 1'b1;
                            end
                            if (k_zrl >= 7'd64) begin
                                blk_valid <= 1'b1;
                                state     <= ST_OUT;
                            end
                        end else if (k_run > 7'd63) begin
                            err       <= 1'b1;
                            blk_err   <= 1'b1;
                            blk_valid <= 1'b1;
                            state     <= ST_OUT;
                        end else begin
                            coeffs[raster_idx*COEFF_W +: COEFF_W] <= ac_val;
                            if (ac_bad) begin
                                err     <= 1'b1;
                                blk_err <= 1'b1;
                            end
                            k <= k_run + 7'd1;
                            if (k_run == 7'd63) begin
                                blk_valid <= 1'b1;
                                state     <= ST_OUT;
                            end
                        end
                    end
                end
                ST_OUT: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_err   <= 1'b0;
                        state     <= ST_WAIT_DC;
                    end
                end
                default: state <= ST_WAIT_DC;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_coeff_block_decoder.sv
// Self-checking bench for jpeg_coeff_block_decoder: directed scenarios plus
// randomized blocks compared against an integer reference model.
module tb_jpeg_coeff_block_decoder;

    localparam int COEFF_W = 10;
    localparam int AMP_W   = 16;
    localparam int CMAX    = (1 << (COEFF_W - 1)) - 1;
    localparam int CMIN    = -(1 << (COEFF_W - 1));

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  sym_valid = 1'b0;
    logic                  sym_ready;
    logic                  sym_is_dc = 1'b0;
    logic [7:0]            sym_rs = '0;
    logic [AMP_W-1:0]      sym_amp = '0;
    logic                  is_luminance = 1'b0;
    logic                  restart = 1'b0;
    logic                  blk_valid;
    logic                  blk_ready = 1'b0;
    logic [64*COEFF_W-1:0] blk_coeffs;
    logic                  blk_is_luminance;
    logic                  blk_err;
    logic                  err;

    int checks = 0;
    int failures = 0;
    int err_mismatch = 0;

    // reference model state (m_state: 0 waiting for DC, 1 collecting AC, 2 block out)
    int zz[64];
    int m_pred[2];
    int m_coeff[64];
    int m_k;
    int m_state;
    bit m_berr;
    bit m_lum;

    always #5 clock = ~clock;

    jpeg_coeff_block_decoder #(
        .COEFF_W (COEFF_W),
        .AMP_W   (AMP_W),
        .SAT_EN  (1'b1)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .sym_valid        (sym_valid),
        .sym_ready        (sym_ready),
        .sym_is_dc        (sym_is_dc),
        .sym_rs           (sym_rs),
        .sym_amp          (sym_amp),
        .is_luminance     (is_luminance),
        .restart          (restart),
        .blk_valid        (blk_valid),
        .blk_ready        (blk_ready),
        .blk_coeffs       (blk_coeffs),
        .blk_is_luminance (blk_is_luminance),
        .blk_err          (blk_err),
        .err              (err)
    );

    // zigzag order built by walking anti-diagonals, alternating direction
    task automatic build_zigzag();
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
            end
        end
    endtask

    function automatic int m_extend(int v, int s);
        int m;
        if (s == 0) return 0;
        m = (1 << s) - 1;
        v = v & m;
        if (v >= (1 << (s - 1))) return v;
        return v - m;
    endfunction

    function automatic int m_clip(int x);
        if (x > CMAX) return CMAX;
        if (x < CMIN) return CMIN;
        return x;
    endfunction

    function automatic int coef(int i);
        logic signed [COEFF_W-1:0] c;
        c = blk_coeffs[i*COEFF_W +: COEFF_W];
        return int'(c);
    endfunction

    function automatic int block_diff(output int first);
        int nd = 0;
        first = 0;
        for (int i = 0; i < 64; i++) begin
            if (coef(i) != m_coeff[i]) begin
                if (nd == 0) first = i;
                nd++;
            end
        end
        return nd;
    endfunction

    task automatic model_reset();
        m_pred[0] = 0; m_pred[1] = 0; m_state = 0; m_k = 0; m_berr = 0; m_lum = 0;
        for (int i = 0; i < 64; i++) m_coeff[i] = 0;
    endtask

    task automatic model_sym(input bit is_dc, input logic [7:0] rs, input int amp,
                             input bit lum, input bit rst, output bit e);
        int run = int'(rs[7:4]);
        int size = int'(rs[3:0]);
        int pos;
        e = 0;
        if (rst) begin m_pred[0] = 0; m_pred[1] = 0; end
        if (m_state == 0) begin
            if (is_dc) begin
                for (int i = 0; i < 64; i++) m_coeff[i] = 0;
                m_berr = (size > 11);
                e = m_berr;
                m_coeff[0] = m_clip(m_pred[lum] + (size > 11 ? 0 : m_extend(amp, size)));
                m_pred[lum] = m_coeff[0];
                m_lum = lum;
                m_k = 1;
                m_state = 1;
            end else begin
                e = 1;
            end
        end else if (m_state == 1) begin
            if (is_dc) begin
                e = 1; m_berr = 1; m_state = 2;
            end else if (rs == 8'h00) begin
                m_state = 2;
            end else if (rs == 8'hF0) begin
                m_k += 16;
                if (m_k > 64) begin e = 1; m_berr = 1; end
                if (m_k >= 64) m_state = 2;
            end else begin
                pos = m_k + run;
                if (pos > 63) begin
                    e = 1; m_berr = 1; m_state = 2;
                end else begin
                    if (size == 0 || size > 10) begin e = 1; m_berr = 1; end
                    else m_coeff[zz[pos]] = m_clip(m_extend(amp, size));
                    m_k = pos + 1;
                    if (m_k == 64) m_state = 2;
                end
            end
        end
    endtask

    // Drives one symbol, holds it until accepted, then updates the model.
    task automatic send_sym(input bit is_dc, input logic [7:0] rs, input logic [AMP_W-1:0] amp,
                            input bit lum, input bit rst);
        bit e;
        int waited = 0;
        sym_valid = 1'b1; sym_is_dc = is_dc; sym_rs = rs; sym_amp = amp;
        is_luminance = lum; restart = rst;
        while (sym_ready !== 1'b1 && waited < 20) begin @(posedge clock); #1; waited++; end
        if (sym_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL sym_accept_timeout: sym_ready=%b required 1", sym_ready);
            sym_valid = 1'b0; restart = 1'b0;
            return;
        end
        @(posedge clock);
        model_sym(is_dc, rs, int'(amp), lum, rst, e);
        #1;
        sym_valid = 1'b0; restart = 1'b0;
        if (err !== e) begin
            err_mismatch++;
            $display("FAIL err_pulse: err=%b required %b (dc=%b rs=%h)", err, e, is_dc, rs);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (blk_valid !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
        ok = (blk_valid === 1'b1);
    endtask

    task automatic take_block();
        blk_ready = 1'b1;
        @(posedge clock); #1;
        blk_ready = 1'b0;
        m_state = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle(3);
        checks++;
        if (sym_ready !== 1'b0) begin failures++; $display("FAIL reset_sym_ready: got %b required 0", sym_ready); end
        checks++;
        if ({blk_valid, blk_err, err, blk_is_luminance} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: valid/err/perr/lum got %b required 0000",
                     {blk_valid, blk_err, err, blk_is_luminance});
        end
        checks++;
        if (blk_coeffs !== '0) begin failures++; $display("FAIL reset_coeffs: got nonzero bus required 0"); end
        reset_n = 1'b1;
        model_reset();
        idle(1);
        checks++;
        if (sym_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b required 1", sym_ready); end
    endtask

    task automatic test_dc();
        int e0 = err_mismatch;
        int first;
        int nd;
        send_sym(1'b1, 8'h03, 16'h0005, 1'b1, 1'b0);
        checks++;
        if (blk_valid !== 1'b0) begin failures++; $display("FAIL dc_early_valid: got %b required 0", blk_valid); end
        send_sym(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (blk_valid !== 1'b1) begin failures++; $display("FAIL dc_latency: blk_valid got %b required 1", blk_valid); end
        checks++;
        if (coef(0) !== 5) begin failures++; $display("FAIL dc_value: got %0d required 5", coef(0)); end
        nd = block_diff(first);
        checks++;
        if (nd !== 0) begin failures++; $display("FAIL dc_block: %0d coeffs differ, first %0d", nd, first); end
        checks++;
        if ({blk_is_luminance, blk_err, sym_ready} !== 3'b100) begin
            failures++; $display("FAIL dc_flags: lum/berr/ready got %b required 100", {blk_is_luminance, blk_err, sym_ready});
        end
        take_block();
        checks++;
        if (blk_valid !== 1'b0) begin failures++; $display("FAIL dc_handshake: blk_valid got %b required 0", blk_valid); end
        checks++;
        if (err_mismatch !== e0) begin failures++; $display("FAIL dc_err_pulses: got %0d mismatches required 0", err_mismatch - e0); end
    endtask

    task automatic test_prediction();
        send_sym(1'b1, 8'h02, 16'h0001, 1'b1, 1'b0);
        send_sym(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (coef(0) !== 3 || m_coeff[0] !== 3) begin failures++; $display("FAIL pred_lum: got %0d required 3", coef(0)); end
        take_block();
        send_sym(1'b1, 8'h00, 16'h0000, 1'b0, 1'b0);
        send_sym(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        checks++;
        if (coef(0) !== 0 || blk_is_luminance !== 1'b0) begin
            failures++; $display("FAIL pred_chroma: got %0d lum=%b required 0 lum=0", coef(0), blk_is_luminance);
        end
        take_block();
        restart = 1'b1;
        idle(1);
        restart = 1'b0;
        m_pred[0] = 0; m_pred[1] = 0;
        send_sym(1'b1, 8'h00, 16'h0000, 1'b1, 1'b0);
        send_sym(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (coef(0) !== 0) begin failures++; $display("FAIL pred_restart: got %0d required 0", coef(0)); end
        take_block();
    endtask

    task automatic test_placement();
        int first;
        int nd;
        send_sym(1'b1, 8'h00, 16'h0000, 1'b1, 1'b1);
        send_sym(1'b0, 8'h01, 16'h0001, 1'b1, 1'b0);
        send_sym(1'b0, 8'h21, 16'h0000, 1'b1, 1'b0);
        send_sym(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (coef(1) !== 1 || coef(9) !== -1) begin
            failures++; $display("FAIL placement: coeff1=%0d coeff9=%0d required 1 -1", coef(1), coef(9));
        end
        nd = block_diff(first);
        checks++;
        if (nd !== 0) begin failures++; $display("FAIL placement_block: %0d coeffs differ, first %0d", nd, first); end
        take_block();
    endtask

    task automatic test_zrl_implicit();
        int first;
        int nd;
        send_sym(1'b1, 8'h00, 16'h0000, 1'b0, 1'b0);
        repeat (3) send_sym(1'b0, 8'hF0, 16'h0000, 1'b0, 1'b0);
        send_sym(1'b0, 8'h32, 16'h0002, 1'b0, 1'b0);
        checks++;
        if (blk_valid !== 1'b0) begin failures++; $display("FAIL zrl_early_valid: got %b required 0", blk_valid); end
        send_sym(1'b0, 8'hA1, 16'h0001, 1'b0, 1'b0);
        checks++;
        if (blk_valid !== 1'b1 || sym_ready !== 1'b0) begin
            failures++; $display("FAIL implicit_end: valid=%b ready=%b required 1 0", blk_valid, sym_ready);
        end
        checks++;
        if (coef(38) !== 2 || coef(63) !== 1) begin
            failures++; $display("FAIL zrl_place: coeff38=%0d coeff63=%0d required 2 1", coef(38), coef(63));
        end
        nd = block_diff(first);
        checks++;
        if (nd !== 0) begin failures++; $display("FAIL zrl_block: %0d coeffs differ, first %0d", nd, first); end
        take_block();
    endtask

    task automatic test_errors();
        int first;
        int nd;
        int e0 = err_mismatch;
        send_sym(1'b0, 8'h11, 16'h0001, 1'b1, 1'b0);
        checks++;
        if (err !== 1'b1 || sym_ready !== 1'b1) begin
            failures++; $display("FAIL stray_ac: err=%b ready=%b required 1 1", err, sym_ready);
        end
        send_sym(1'b1, 8'h00, 16'h0000, 1'b1, 1'b0);
        repeat (3) send_sym(1'b0, 8'hF0, 16'h0000, 1'b1, 1'b0);
        send_sym(1'b0, 8'hA1, 16'h0001, 1'b1, 1'b0);
        send_sym(1'b0, 8'h51, 16'h0001, 1'b1, 1'b0);
        checks++;
        if ({err, blk_valid, blk_err} !== 3'b111) begin
            failures++; $display("FAIL overrun: err/valid/berr got %b required 111", {err, blk_valid, blk_err});
        end
        nd = block_diff(first);
        checks++;
        if (nd !== 0) begin failures++; $display("FAIL overrun_block: %0d coeffs differ, first %0d", nd, first); end
        take_block();
        checks++;
        if (blk_err !== 1'b0) begin failures++; $display("FAIL berr_clear: got %b required 0", blk_err); end
        send_sym(1'b1, 8'h09, 16'd500, 1'b1, 1'b1);
        send_sym(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (coef(0) !== 500) begin failures++; $display("FAIL pred_load: got %0d required 500", coef(0)); end
        take_block();
        send_sym(1'b1, 8'h07, 16'd100, 1'b1, 1'b0);
        send_sym(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (coef(0) !== 511) begin failures++; $display("FAIL dc_saturate: got %0d required 511", coef(0)); end
        take_block();
        send_sym(1'b1, 8'h0C, 16'h0FFF, 1'b1, 1'b0);
        send_sym(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (coef(0) !== 511 || blk_err !== 1'b1) begin
            failures++; $display("FAIL dc_bad_size: coeff0=%0d berr=%b required 511 1", coef(0), blk_err);
        end
        take_block();
        checks++;
        if (err_mismatch !== e0) begin failures++; $display("FAIL error_pulses: got %0d mismatches required 0", err_mismatch - e0); end
    endtask

    task automatic test_backpressure_reset();
        logic [64*COEFF_W-1:0] held;
        int bad = 0;
        int first;
        int nd;
        send_sym(1'b1, 8'h04, 16'($urandom), 1'b0, 1'b0);
        send_sym(1'b0, 8'h03, 16'($urandom), 1'b0, 1'b0);
        send_sym(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        held = blk_coeffs;
        sym_valid = 1'b1; sym_is_dc = 1'b1; sym_rs = 8'h05; sym_amp = 16'h001F;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            if (blk_coeffs !== held || blk_valid !== 1'b1 || sym_ready !== 1'b0) bad++;
        end
        sym_valid = 1'b0;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL backpressure_hold: %0d unstable cycles required 0", bad); end
        nd = block_diff(first);
        checks++;
        if (nd !== 0) begin failures++; $display("FAIL backpressure_block: %0d coeffs differ, first %0d", nd, first); end
        take_block();
        send_sym(1'b1, 8'h05, 16'($urandom), 1'b1, 1'b0);
        send_sym(1'b0, 8'h02, 16'($urandom), 1'b1, 1'b0);
        reset_n = 1'b0;
        idle(1);
        checks++;
        if (blk_valid !== 1'b0 || blk_coeffs !== '0 || sym_ready !== 1'b0) begin
            failures++; $display("FAIL mid_reset: valid=%b ready=%b coeffs_zero=%b required 0 0 1",
                                 blk_valid, sym_ready, blk_coeffs == '0);
        end
        reset_n = 1'b1;
        model_reset();
        idle(1);
        send_sym(1'b1, 8'h00, 16'h0000, 1'b1, 1'b0);
        send_sym(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (coef(0) !== 0 || blk_valid !== 1'b1) begin
            failures++; $display("FAIL post_reset_block: coeff0=%0d valid=%b required 0 1", coef(0), blk_valid);
        end
        take_block();
    endtask

    task automatic test_random_blocks();
        int e0 = err_mismatch;
        int first;
        int nd;
        int dcs;
        int n;
        int r;
        bit lum;
        bit ok;
        logic [7:0] rs;
        for (int b = 0; b < 40; b++) begin
            lum = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) send_sym(1'b0, 8'h11, 16'($urandom), lum, 1'b0);
            dcs = ($urandom_range(0, 15) == 0) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 11));
            send_sym(1'b1, 8'(dcs), 16'($urandom), lum, $urandom_range(0, 9) == 0);
            n = 0;
            while (m_state == 1 && n < 80) begin
                r = int'($urandom_range(0, 99));
                if (r < 8)       send_sym(1'b0, 8'h00, 16'($urandom), lum, 1'b0);
                else if (r < 16) send_sym(1'b0, 8'hF0, 16'($urandom), lum, 1'b0);
                else if (r < 19) send_sym(1'b1, 8'h03, 16'($urandom), lum, 1'b0);
                else begin
                    rs = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 11))};
                    send_sym(1'b0, rs, 16'($urandom), lum, 1'b0);
                end
                if ($urandom_range(0, 3) == 0) idle(1);
                n++;
            end
            wait_valid(ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL rand_valid_timeout: block %0d blk_valid=%b required 1", b, blk_valid); end
            nd = block_diff(first);
            checks++;
            if (nd !== 0) begin
                failures++;
                $display("FAIL rand_coeffs: block %0d, %0d differ, first raster %0d got %0d required %0d",
                         b, nd, first, coef(first), m_coeff[first]);
            end
            checks++;
            if (blk_err !== m_berr || blk_is_luminance !== m_lum) begin
                failures++; $display("FAIL rand_flags: block %0d berr=%b lum=%b required %b %b",
                                     b, blk_err, blk_is_luminance, m_berr, m_lum);
            end
            idle(int'($urandom_range(0, 3)));
            take_block();
        end
        checks++;
        if (err_mismatch !== e0) begin failures++; $display("FAIL rand_err_pulses: got %0d mismatches required 0", err_mismatch - e0); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_zigzag();
        model_reset();
        test_reset();
        test_dc();
        test_prediction();
        test_placement();
        test_zrl_implicit();
        test_errors();
        test_backpressure_reset();
        test_random_blocks();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
